// File: rtl/fetch_prefetch_queue.sv
// Prefetching instruction-fetch front end: credit-limited in-order requests, PC-tagged FIFO, registered decode outputs.
// Optional PREFETCH_BYPASS_EN writes a live response straight into the output register when the FIFO is empty.
module fetch_prefetch_queue #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_src,
   input  logic [31:0] pc_target,
   input  logic        stall_d,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_4,
   output logic        instr_valid
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int DISC_W = 8;
   localparam logic [PTR_W-1:0]  PTR_ONE  = 1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
   localparam logic [DISC_W-1:0] DISC_ONE = 1;

   logic [31:0]       fetch_pc;
   logic [31:0]       fifo_instr [DEPTH];
   logic [31:0]       fifo_pc    [DEPTH];
   logic [31:0]       tag_pc     [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr, tag_wr, tag_rd;
   logic [CNT_W-1:0]  fifo_count, outstanding;
   logic [DISC_W-1:0] discard;
   logic [CNT_W:0]    in_use;
   logic              credit_ok, req_fire, resp_live, resp_drop, push, pop, bypass;

   assign in_use         = {1'b0, fifo_count} + {1'b0, outstanding};
   assign credit_ok      = in_use < (CNT_W+1)'(DEPTH);
   assign imem_req_valid = rst & ~pc_src & credit_ok;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign resp_drop      = imem_resp_valid & (discard != '0);
   assign resp_live      = imem_resp_valid & (discard == '0);

`ifdef PREFETCH_BYPASS_EN
   assign bypass = resp_live & (fifo_count == '0) & ~stall_d & ~pc_src;
`else
   assign bypass = 1'b0;
`endif

   assign push = resp_live & ~bypass & ~pc_src;
   assign pop  = ~stall_d & ~pc_src & (fifo_count != '0);

   // Storage arrays carry no reset; validity is tracked by the pointers and counts.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= imem_resp_data;
         fifo_pc[wr_ptr]    <= tag_pc[tag_rd];
      end
      if (req_fire)
         tag_pc[tag_wr] <= fetch_pc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
         fifo_count  <= '0;
         outstanding <= '0;
         discard     <= '0;
         instr       <= NOP_INSTR;
         pc          <= '0;
         pc_4        <= '0;
         instr_valid <= 1'b0;
      end else if (pc_src) begin
         // Squashed responses arrive ahead of all new ones, so the tag queue simply restarts empty.
         // Any response this cycle retires one in-flight word, whether it was live or already doomed.
         fetch_pc    <= pc_target & ~32'h3;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
         fifo_count  <= '0;
         outstanding <= '0;
         discard     <= discard + DISC_W'(outstanding) - (imem_resp_valid ? DISC_ONE : '0);
         instr       <= NOP_INSTR;
         instr_valid <= 1'b0;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
            tag_wr   <= tag_wr + PTR_ONE;
         end
         if (resp_drop)
            discard <= discard - DISC_ONE;
         if (resp_live)
            tag_rd <= tag_rd + PTR_ONE;
         if (req_fire && !resp_live)
            outstanding <= outstanding + CNT_ONE;
         else if (!req_fire && resp_live)
            outstanding <= outstanding - CNT_ONE;
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)
            fifo_count <= fifo_count + CNT_ONE;
         else if (!push && pop)
            fifo_count <= fifo_count - CNT_ONE;

         if (!stall_d) begin
            if (bypass) begin
               instr       <= imem_resp_data;
               pc          <= tag_pc[tag_rd];
               pc_4        <= tag_pc[tag_rd] + 32'd4;
               instr_valid <= 1'b1;
            end else if (fifo_count != '0) begin
               instr       <= fifo_instr[rd_ptr];
               pc          <= fifo_pc[rd_ptr];
               pc_4        <= fifo_pc[rd_ptr] + 32'd4;
               instr_valid <= 1'b1;
            end else begin
               instr       <= NOP_INSTR;
               instr_valid <= 1'b0;
            end
         end
      end
   end

   // The credit rule must keep a live response from ever landing on a full FIFO.
   assert property (@(posedge clk) disable iff (!rst)
      (imem_resp_valid && discard == '0) |-> (fifo_count != CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: in-order variable-latency memory model, PC scoreboard, vector table and redirect/reset sequences.
module tb_fetch_prefetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_src = 1'b0;
   logic [31:0] pc_target = 32'h0;
   logic        stall_d = 1'b0;
   logic        imem_req_ready = 1'b0;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic [31:0] instr, pc, pc_4;
   logic        instr_valid;

   fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .pc_src(pc_src), .pc_target(pc_target), .stall_d(stall_d),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .instr(instr), .pc(pc), .pc_4(pc_4), .instr_valid(instr_valid)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } mem_req_t;
   typedef struct {
      logic stall; logic ready; logic exp_req;
      logic exp_valid; logic [31:0] exp_pc; logic [31:0] exp_pc4; logic [31:0] exp_instr;
   } vec_t;

   mem_req_t    mem_q[$];
   logic [31:0] sb_q[$];
   int          cyc = 0, lat = 1, checks = 0, errors = 0, presented = 0, edge_kind = 0;
   logic [31:0] exp_fetch = RESET_PC;
   logic [31:0] prev_instr = NOP, prev_pc = 32'h0, prev_pc4 = 32'h0;
   logic        prev_valid = 1'b0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Memory acceptance, response consumption and the fetch-address/credit model all live on the rising edge.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         check_output("req_valid_credit", 32'(imem_req_valid), 32'((sb_q.size() < DEPTH) && !pc_src));
         if (imem_resp_valid && mem_q.size() > 0)
            void'(mem_q.pop_front());
         if (imem_req_valid && imem_req_ready) begin
            check_output("req_addr", imem_req_addr, exp_fetch);
            mem_q.push_back('{imem_req_addr, cyc + lat - 1});
            sb_q.push_back(exp_fetch);
            exp_fetch += 32'd4;
         end
         if (pc_src) begin
            sb_q.delete();
            exp_fetch = pc_target & ~32'h3;
            edge_kind = 2;
         end else begin
            edge_kind = stall_d ? 0 : 1;
         end
         check_output("inflight_bound", 32'(sb_q.size() <= DEPTH), 32'd1);
      end else begin
         mem_q.delete();
         sb_q.delete();
         exp_fetch = RESET_PC;
         edge_kind = 0;
      end
   end

   // Word-index memory: data is the word address, returned in order once due.
   always @(negedge clk) begin
      if (rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_q[0].addr >> 2;
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'hDEAD_BEEF;
      end
   end

   // Decode-side monitor: every newly loaded valid word must be the next surviving fetch in program order.
   always @(negedge clk) begin
      if (rst) begin
         if (edge_kind == 1 && instr_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_instr actual pc=%h required no valid output", pc);
            end else begin
               logic [31:0] exp_pc;
               exp_pc = sb_q.pop_front();
               check_output("sb_pc", pc, exp_pc);
               check_output("sb_instr", instr, exp_pc >> 2);
               check_output("sb_pc_4", pc_4, exp_pc + 32'd4);
               presented++;
            end
         end else if (edge_kind == 1) begin
            check_output("bubble_instr", instr, NOP);
            check_output("bubble_pc_hold", pc, prev_pc);
         end else if (edge_kind == 2) begin
            check_output("redirect_instr", instr, NOP);
            check_output("redirect_valid", 32'(instr_valid), 32'd0);
         end else begin
            check_output("hold_instr", instr, prev_instr);
            check_output("hold_pc", pc, prev_pc);
            check_output("hold_pc_4", pc_4, prev_pc4);
            check_output("hold_valid", 32'(instr_valid), 32'(prev_valid));
         end
         prev_instr = instr;
         prev_pc    = pc;
         prev_pc4   = pc_4;
         prev_valid = instr_valid;
      end
   end

   task automatic clear_model();
      mem_q.delete();
      sb_q.delete();
      exp_fetch       = RESET_PC;
      imem_resp_valid = 1'b0;
      prev_instr      = NOP;
      prev_pc         = 32'h0;
      prev_pc4        = 32'h0;
      prev_valid      = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, "_instr"}, instr, NOP);
      check_output({tag, "_pc"}, pc, 32'h0);
      check_output({tag, "_pc_4"}, pc_4, 32'h0);
      check_output({tag, "_valid"}, 32'(instr_valid), 32'd0);
      check_output({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
   endtask

   task automatic wait_first_valid(input string name, input int max_cycles, input logic [31:0] exp_pc);
      bit seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         @(negedge clk);
         if (instr_valid) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s actual=timeout required pc=%h", name, exp_pc);
      end else begin
         check_output(name, pc, exp_pc);
      end
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      stall_d        = v.stall;
      imem_req_ready = v.ready;
      #1;
      check_output($sformatf("vec%0d_req_valid", idx), 32'(imem_req_valid), 32'(v.exp_req));
      @(negedge clk);
      check_output($sformatf("vec%0d_valid", idx), 32'(instr_valid), 32'(v.exp_valid));
      check_output($sformatf("vec%0d_pc", idx), pc, v.exp_pc);
      check_output($sformatf("vec%0d_pc_4", idx), pc_4, v.exp_pc4);
      check_output($sformatf("vec%0d_instr", idx), instr, v.exp_instr);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        vecs[16];
      logic [3:0]  ready_pat;
      int          start_count;

      // Stream from reset with 1-cycle memory, then a 6-cycle decode stall at pc=0x8.
      for (int i = 0; i < 16; i++) begin
         logic [31:0] p;
         if (i < 2) p = 32'h0;
         else if (i < 5) p = 32'(4 * (i - 2));
         else if (i < 11) p = 32'h8;
         else p = 32'(4 * (i - 8));
         vecs[i].stall     = (i >= 5 && i <= 10);
         vecs[i].ready     = 1'b1;
         vecs[i].exp_req   = !(i >= 7 && i <= 11);
         vecs[i].exp_valid = (i >= 2);
         vecs[i].exp_pc    = p;
         vecs[i].exp_pc4   = (i >= 2) ? p + 32'd4 : 32'h0;
         vecs[i].exp_instr = (i >= 2) ? p >> 2 : NOP;
      end

      #2 rst = 1'b0;
      clear_model();
      #1 check_reset_state("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 16; i++) apply_stimulus(vecs[i], i);

      $display("[TB] redirect with requests in flight");
      lat = 3;
      repeat (10) @(negedge clk);
      pc_src    = 1'b1;
      pc_target = 32'h0000_0103;
      #1 check_output("redirect_req_valid", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      pc_src = 1'b0;
      check_output("redirect_bubble_instr", instr, NOP);
      check_output("redirect_bubble_valid", 32'(instr_valid), 32'd0);
      wait_first_valid("first_after_redirect", 40, 32'h0000_0100);

      $display("[TB] back-to-back redirects");
      repeat (3) @(negedge clk);
      pc_src    = 1'b1;
      pc_target = 32'h0000_0200;
      #1 check_output("redirect2a_req_valid", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      pc_target = 32'h0000_0300;
      #1 check_output("redirect2b_req_valid", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      pc_src = 1'b0;
      wait_first_valid("first_after_double_redirect", 40, 32'h0000_0300);

      $display("[TB] ready toggling with 3-cycle memory");
      ready_pat   = 4'b1001;
      start_count = presented;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         imem_req_ready = ready_pat[i % 4];
      end
      @(negedge clk);
      imem_req_ready = 1'b1;
      check_output("toggle_progress", 32'((presented - start_count) >= 8), 32'd1);

      $display("[TB] address wrap at top of memory");
      lat = 1;
      repeat (4) @(negedge clk);
      pc_src    = 1'b1;
      pc_target = 32'hFFFF_FFFA;
      @(negedge clk);
      pc_src = 1'b0;
      wait_first_valid("wrap_pc_fff8", 40, 32'hFFFF_FFF8);
      wait_first_valid("wrap_pc_fffc", 4, 32'hFFFF_FFFC);
      check_output("wrap_pc_4_zero", pc_4, 32'h0);
      wait_first_valid("wrap_pc_zero", 4, 32'h0);

      $display("[TB] asynchronous reset mid-stream");
      repeat (5) @(negedge clk);
      #3 rst = 1'b0;
      clear_model();
      #1 check_reset_state("async_reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      wait_first_valid("first_after_reset", 20, RESET_PC);
      repeat (6) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
